// File: rtl/wtm_mac.sv
// wtm_mac: multiply-accumulate stage behind a 5x5 Wallace tree multiplier.
// Operand pairs arrive over a valid/ready handshake and are registered once.
// N_TERMS products are summed into an ACC_W-bit accumulator, and the sum is
// then offered on a second valid/ready handshake. The file also contains the
// wtm multiplier itself, so the block is self-contained.

module wtm (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [9:0] out,
  output logic       cout
);

  // Carry-save sum bit of three rows.
  function automatic logic [10:0] csa_sum(input logic [10:0] x, input logic [10:0] y,
                                          input logic [10:0] z);
    csa_sum = x ^ y ^ z;
  endfunction

  // Carry-save carry bits of three rows, moved up to the next weight.
  function automatic logic [10:0] csa_carry(input logic [10:0] x, input logic [10:0] y,
                                            input logic [10:0] z);
    csa_carry = ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [10:0] pp_s [5];
  logic [10:0] s1_s, c1_s, s2_s, c2_s, s3_s, c3_s;
  logic [10:0] final_s;

  // Partial products, then three carry-save layers and one carry-propagate add.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      if (b[i]) begin
        pp_s[i] = {6'b000000, a} << i;
      end else begin
        pp_s[i] = 11'd0;
      end
    end
    s1_s    = csa_sum(pp_s[0], pp_s[1], pp_s[2]);
    c1_s    = csa_carry(pp_s[0], pp_s[1], pp_s[2]);
    s2_s    = csa_sum(s1_s, c1_s, pp_s[3]);
    c2_s    = csa_carry(s1_s, c1_s, pp_s[3]);
    s3_s    = csa_sum(s2_s, c2_s, pp_s[4]);
    c3_s    = csa_carry(s2_s, c2_s, pp_s[4]);
    final_s = s3_s + c3_s;
  end

  assign out  = final_s[9:0];
  assign cout = final_s[10];

endmodule

module wtm_mac #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_a,
  input  logic [4:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [7:0] N_TERMS_C = 8'(N_TERMS);
  localparam logic [7:0] N_LAST_C  = 8'(N_TERMS - 1);

  state_t           state_r;
  logic [4:0]       a_r;
  logic [4:0]       b_r;
  logic             v_r;
  logic [7:0]       cnt_in_r;
  logic [7:0]       cnt_acc_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;

  logic [9:0]       prod_lo_s;
  logic             prod_hi_s;
  logic [10:0]      prod_s;
  logic [ACC_W:0]   acc_sum_s;
  logic             hs_in_s;

  wtm u_wtm (
    .a    (a_r),
    .b    (b_r),
    .out  (prod_lo_s),
    .cout (prod_hi_s)
  );

  assign prod_s    = {prod_hi_s, prod_lo_s};
  // One extra bit on the adder captures the carry out of the accumulator MSB.
  assign acc_sum_s = {1'b0, acc_r} + (ACC_W + 1)'(prod_s);

  // Ready depends only on registered state (and reset), never on in_valid.
  assign in_ready  = rst_n && (state_r == ST_ACC) && (cnt_in_r < N_TERMS_C);
  assign hs_in_s   = in_valid && in_ready;

  assign out_valid = (state_r == ST_DONE);
  assign out_sum   = acc_r;
  assign out_ovf   = ovf_r;

  // Operand register, accumulator, counters and the ACC/DONE state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_ACC;
      a_r       <= 5'd0;
      b_r       <= 5'd0;
      v_r       <= 1'b0;
      cnt_in_r  <= 8'd0;
      cnt_acc_r <= 8'd0;
      acc_r     <= '0;
      ovf_r     <= 1'b0;
    end else begin
      if (hs_in_s) begin
        a_r      <= in_a;
        b_r      <= in_b;
        v_r      <= 1'b1;
        cnt_in_r <= cnt_in_r + 8'd1;
      end else begin
        v_r      <= 1'b0;
      end
      case (state_r)
        ST_ACC: begin
          if (v_r) begin
            acc_r     <= acc_sum_s[ACC_W-1:0];
            ovf_r     <= ovf_r | acc_sum_s[ACC_W];
            cnt_acc_r <= cnt_acc_r + 8'd1;
            if (cnt_acc_r == N_LAST_C) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_ACC;
            end
          end else begin
            state_r <= ST_ACC;
          end
        end
        ST_DONE: begin
          // in_ready is low here, so no accept can collide with this clear.
          if (out_ready) begin
            acc_r     <= '0;
            ovf_r     <= 1'b0;
            cnt_in_r  <= 8'd0;
            cnt_acc_r <= 8'd0;
            state_r   <= ST_ACC;
          end else begin
            state_r   <= ST_DONE;
          end
        end
        default: begin
          acc_r     <= '0;
          ovf_r     <= 1'b0;
          cnt_in_r  <= 8'd0;
          cnt_acc_r <= 8'd0;
          state_r   <= ST_ACC;
        end
      endcase
    end
  end

endmodule
